matmul_result_buffer: RTL

- Downstream stage of the systolic matrix multiplier: captures C elements from its (c_data, c_row, c_col, c_valid, done) output stream, which can arrive in any order.
- Holds a full M x N tile and replays it in strict row-major order over a valid/ready stream to the next transformer stage (bias/softmax).
- Decouples the multiplier's fire-and-forget output from a back-pressured consumer.

---
 rtl/matmul_result_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/matmul_result_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | matmul_result_buffer: captures an out-of-order M x N tile from the systolic |
// | multiplier and replays it row-major over valid/ready. Option: RESULT_BUF_RELU_EN |
// | Revision: 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module matmul_result_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int M          = 5,
  parameter int N          = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic signed [DATA_WIDTH-1:0]  c_data,
  input  logic        [$clog2(M)-1:0]   c_row,
  input  logic        [$clog2(N)-1:0]   c_col,
  input  logic                          c_valid,
  input  logic                          mm_done,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic        [$clog2(M)-1:0]   out_row,
  output logic        [$clog2(N)-1:0]   out_col,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          tile_done,
  output logic        [2:0]             err
);

  // FRAC_WIDTH only documents the Q format; elements are moved, never scaled.
  localparam int DW    = DATA_WIDTH + 0 * FRAC_WIDTH;
  localparam int DEPTH = M * N;
  localparam int RW    = $clog2(M);
  localparam int CLW   = $clog2(N);
  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = $clog2(DEPTH + 1);

  localparam logic [RW-1:0]  ROW_LAST = RW'(M - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(N - 1);
  localparam logic [NW-1:0]  CNT_FULL = NW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic signed [DW-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]     written_q, written_d;
  logic [NW-1:0]        count_q, count_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CLW-1:0]       col_q, col_d;
  logic [2:0]           err_q, err_d;
  logic                 tile_done_q, tile_done_d;

  logic                 w_in_range;
  logic [AW-1:0]        w_wr_addr;
  logic [AW-1:0]        w_rd_addr;
  logic                 w_wr;
  logic                 w_new;
  logic [NW-1:0]        w_count_after;
  logic                 w_full;
  logic                 w_at_last;
  logic signed [DW-1:0] w_stored;

  assign w_in_range    = (c_row <= ROW_LAST) && (c_col <= COL_LAST);
  assign w_wr_addr     = AW'(c_row) * AW'(N) + AW'(c_col);
  assign w_rd_addr     = AW'(row_q) * AW'(N) + AW'(col_q);
  assign w_wr          = (state_q == COLLECT) && c_valid && w_in_range;
  assign w_new         = w_wr && !written_q[w_wr_addr];
  assign w_count_after = count_q + NW'(w_new);
  assign w_full        = (w_count_after == CNT_FULL);
  assign w_at_last     = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d     = state_q;
    written_d   = written_q;
    count_d     = count_q;
    err_d       = err_q;
    row_d       = row_q;
    col_d       = col_q;
    tile_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          written_d = '0;
          count_d   = '0;
          err_d     = '0;
        end
      end
      COLLECT: begin
        if (start) begin
          written_d = '0;
          count_d   = '0;
          err_d     = '0;
        end else begin
          if (w_wr) begin
            written_d[w_wr_addr] = 1'b1;
            if (!w_new) err_d[0] = 1'b1;
          end
          if (c_valid && !w_in_range) err_d[1] = 1'b1;
          count_d = w_count_after;
          // Same-cycle element is already counted before judging completeness.
          if (mm_done && !w_full) err_d[2] = 1'b1;
          if (w_full || mm_done) begin
            state_d = DRAIN;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (start) begin
          state_d   = COLLECT;
          written_d = '0;
          count_d   = '0;
          err_d     = '0;
          row_d     = '0;
          col_d     = '0;
        end else if (out_ready) begin
          if (w_at_last) begin
            state_d     = IDLE;
            tile_done_d = 1'b1;
            row_d       = '0;
            col_d       = '0;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      written_q   <= '0;
      count_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      err_q       <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      written_q   <= written_d;
      count_q     <= count_d;
      row_q       <= row_d;
      col_q       <= col_d;
      err_q       <= err_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Storage needs no reset: the written flags mask stale contents.
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[w_wr_addr] <= c_data;
  end

  assign w_stored  = written_q[w_rd_addr] ? mem_q[w_rd_addr] : '0;
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = out_valid && w_at_last;
  assign tile_done = tile_done_q;
  assign err       = err_q;

`ifdef RESULT_BUF_RELU_EN
  assign out_data = (out_valid && !w_stored[DW-1]) ? w_stored : '0;
`else
  assign out_data = out_valid ? w_stored : '0;
`endif

endmodule
`default_nettype wire
